// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: flush cause codes, redirect FSM encoding and the
// CSR numbers WB uses to pick exception entry points.
package cpu_defs_pkg;

  localparam logic [1:0] FLUSH_CAUSE_NONE    = 2'b00;
  localparam logic [1:0] FLUSH_CAUSE_EX      = 2'b01;
  localparam logic [1:0] FLUSH_CAUSE_ERTN    = 2'b10;
  localparam logic [1:0] FLUSH_CAUSE_REFETCH = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } flush_state_e;

  localparam logic [13:0] CSR_EENTRY    = 14'hc;
  localparam logic [13:0] CSR_TLBRENTRY = 14'h88;

  // Exception beats ertn, which beats refetch, when several fire together.
  function automatic logic [1:0] flush_cause_sel(input logic ex,
                                                 input logic ertn,
                                                 input logic refetch);
    if (ex)           return FLUSH_CAUSE_EX;
    else if (ertn)    return FLUSH_CAUSE_ERTN;
    else if (refetch) return FLUSH_CAUSE_REFETCH;
    else              return FLUSH_CAUSE_NONE;
  endfunction

endpackage

// File: rtl/flush_ctrl_inflight_tracker.sv
// In-flight inst-fetch bookkeeping: counts every accepted fetch whose data
// has not returned, and how many of those are stale after a flush, so IF
// can discard their responses.
module inflight_tracker
  import cpu_defs_pkg::*;
#(
  parameter int MAX_OUTST = 2,
  parameter int CNT_W     = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush_ev,
  input  logic             inst_sram_req,
  input  logic             inst_sram_addr_ok,
  input  logic             inst_sram_data_ok,
  output logic [CNT_W-1:0] outst_cnt,
  output logic             if_drop_data
);

  // Stale count may reach MAX_OUTST + 1 (full pipe plus a pending request).
  localparam int DROP_W = $clog2(MAX_OUTST + 2);

  logic              addr_acc;
  logic [CNT_W-1:0]  outst_next;
  logic [DROP_W-1:0] drop_cnt;
  logic [DROP_W-1:0] drop_next;
  logic [DROP_W-1:0] flush_sum;
  logic              req_pend_drop;
  logic              pend_next;

  assign addr_acc     = inst_sram_req & inst_sram_addr_ok;
  assign if_drop_data = inst_sram_data_ok & ((drop_cnt != '0) | flush_ev);

  // Next-state computation for both counters and the pending-request flag.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch; blocking '=' is right here.
    outst_next = outst_cnt;
    drop_next  = drop_cnt;
    flush_sum  = DROP_W'(outst_cnt) + DROP_W'(addr_acc);
    pend_next  = req_pend_drop & ~addr_acc;

    // Saturating in-flight count; a data_ok with nothing outstanding holds 0.
    if (addr_acc && !inst_sram_data_ok && outst_cnt != CNT_W'(MAX_OUTST))
      outst_next = outst_cnt + CNT_W'(1);
    else if (inst_sram_data_ok && !addr_acc && outst_cnt != '0)
      outst_next = outst_cnt - CNT_W'(1);

    // A data_ok in the flush cycle is dropped directly, so it is not counted.
    if (inst_sram_data_ok && flush_sum != '0)
      flush_sum = flush_sum - DROP_W'(1);

    if (flush_ev) begin
      drop_next = flush_sum;
      // A raised but unaccepted req cannot be withdrawn, so it is already stale.
      pend_next = (inst_sram_req & ~inst_sram_addr_ok) | (req_pend_drop & ~addr_acc);
    end else begin
      if (req_pend_drop && addr_acc && drop_cnt != DROP_W'(MAX_OUTST + 1))
        drop_next = drop_next + DROP_W'(1);
      if (inst_sram_data_ok && drop_cnt != '0)
        drop_next = drop_next - DROP_W'(1);
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outst_cnt     <= '0;
      drop_cnt      <= '0;
      req_pend_drop <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking '<=' so every register
      // samples pre-edge values regardless of statement order.
      outst_cnt     <= outst_next;
      drop_cnt      <= drop_next;
      req_pend_drop <= pend_next;
    end
  end

endmodule

// File: rtl/flush_ctrl.sv
// Pipeline-redirect sequencer between WB and IF: merges WB flush sources
// into a one-cycle flush, holds the redirect target until IF takes it, and
// tells IF which fetch responses are stale.
module flush_ctrl
  import cpu_defs_pkg::*;
#(
  parameter int MAX_OUTST = 2,
  parameter int CNT_W     = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_ex,
  input  logic        ertn_flush,
  input  logic        wb_refetch_flush,
  input  logic [31:0] wb_flush_entry,
  input  logic        inst_sram_req,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic        if_redirect_ack,
  output logic        flush_all,
  output logic [1:0]  flush_cause,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        if_drop_data,
  output logic        fetch_block
);

  flush_state_e     state;
  logic [CNT_W-1:0] outst_cnt;

  // Flush is combinational and suppressed while reset is held.
  assign flush_all   = (wb_ex | ertn_flush | wb_refetch_flush) & resetn;
  assign flush_cause = flush_all ? flush_cause_sel(wb_ex, ertn_flush, wb_refetch_flush)
                                 : FLUSH_CAUSE_NONE;
  assign fetch_block = (state == REDIR) | (outst_cnt == CNT_W'(MAX_OUTST));

  inflight_tracker #(
    .MAX_OUTST (MAX_OUTST),
    .CNT_W     (CNT_W)
  ) u_tracker (
    .clk               (clk),
    .resetn            (resetn),
    .flush_ev          (flush_all),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .outst_cnt         (outst_cnt),
    .if_drop_data      (if_drop_data)
  );

  // Redirect FSM; the newest flush always overwrites the pending target.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_all) begin
            state          <= REDIR;
            redirect_valid <= 1'b1;
            redirect_pc    <= wb_flush_entry;
          end
        end
        REDIR: begin
          if (flush_all) begin
            redirect_pc <= wb_flush_entry;
          end else if (if_redirect_ack) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flush_ctrl.sv
// Directed bench for flush_ctrl: expected values are queued when stimulus
// is driven and popped when the outputs are sampled.
module tb_flush_ctrl;
  import cpu_defs_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_ex, ertn_flush, wb_refetch_flush;
  logic [31:0] wb_flush_entry;
  logic        inst_sram_req, inst_sram_addr_ok, inst_sram_data_ok;
  logic        if_redirect_ack;
  logic        flush_all;
  logic [1:0]  flush_cause;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_drop_data;
  logic        fetch_block;

  always #5 clk = ~clk;

  flush_ctrl #(.MAX_OUTST(2), .CNT_W(2)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .wb_ex             (wb_ex),
    .ertn_flush        (ertn_flush),
    .wb_refetch_flush  (wb_refetch_flush),
    .wb_flush_entry    (wb_flush_entry),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .if_redirect_ack   (if_redirect_ack),
    .flush_all         (flush_all),
    .flush_cause       (flush_cause),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .if_drop_data      (if_drop_data),
    .fetch_block       (fetch_block)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %0h, nothing expected", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val && tag == e.tag) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h (queued as %s)", tag, obs, e.val, e.tag);
      end
    end
  endtask

  task automatic expect_outs(input string tag, input logic fa, input logic [1:0] cause,
                             input logic rv, input logic [31:0] pc,
                             input logic dd, input logic fb);
    push({tag, ".flush_all"}, 32'(fa));
    push({tag, ".flush_cause"}, 32'(cause));
    push({tag, ".redirect_valid"}, 32'(rv));
    push({tag, ".redirect_pc"}, pc);
    push({tag, ".if_drop_data"}, 32'(dd));
    push({tag, ".fetch_block"}, 32'(fb));
  endtask

  task automatic observe_outs(input string tag);
    check({tag, ".flush_all"}, 32'(flush_all));
    check({tag, ".flush_cause"}, 32'(flush_cause));
    check({tag, ".redirect_valid"}, 32'(redirect_valid));
    check({tag, ".redirect_pc"}, redirect_pc);
    check({tag, ".if_drop_data"}, 32'(if_drop_data));
    check({tag, ".fetch_block"}, 32'(fetch_block));
  endtask

  task automatic clear_in();
    wb_ex             = 1'b0;
    ertn_flush        = 1'b0;
    wb_refetch_flush  = 1'b0;
    wb_flush_entry    = 32'h0;
    inst_sram_req     = 1'b0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    if_redirect_ack   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    clear_in();

    // Reset state
    expect_outs("reset", 0, FLUSH_CAUSE_NONE, 0, 32'h0, 0, 0);
    #2;
    observe_outs("reset");
    #15 resetn = 1'b1;
    tick();

    // Idle flush by exception
    wb_ex = 1'b1; wb_flush_entry = 32'h1c008000;
    expect_outs("idle_flush", 1, FLUSH_CAUSE_EX, 0, 32'h0, 0, 0);
    @(negedge clk); observe_outs("idle_flush"); tick();
    clear_in();
    expect_outs("redir1", 0, FLUSH_CAUSE_NONE, 1, 32'h1c008000, 0, 1);
    @(negedge clk); observe_outs("redir1"); tick();
    expect_outs("redir2", 0, FLUSH_CAUSE_NONE, 1, 32'h1c008000, 0, 1);
    @(negedge clk); observe_outs("redir2"); tick();
    if_redirect_ack = 1'b1;
    expect_outs("ack_cyc", 0, FLUSH_CAUSE_NONE, 1, 32'h1c008000, 0, 1);
    @(negedge clk); observe_outs("ack_cyc"); tick();
    clear_in();
    expect_outs("post_ack", 0, FLUSH_CAUSE_NONE, 0, 32'h1c008000, 0, 0);
    @(negedge clk); observe_outs("post_ack"); tick();

    // Stale drop: two fetches in flight, then ertn
    inst_sram_req = 1'b1; inst_sram_addr_ok = 1'b1;
    push("acc1.fetch_block", 32'd0);
    @(negedge clk); check("acc1.fetch_block", 32'(fetch_block)); tick();
    push("acc2.fetch_block", 32'd0);
    @(negedge clk); check("acc2.fetch_block", 32'(fetch_block)); tick();
    clear_in();
    ertn_flush = 1'b1; wb_flush_entry = 32'h1c001000;
    expect_outs("ertn", 1, FLUSH_CAUSE_ERTN, 0, 32'h1c008000, 0, 1);
    @(negedge clk); observe_outs("ertn"); tick();
    clear_in();
    inst_sram_data_ok = 1'b1;
    push("ertn.drop_cnt", 32'd2);
    expect_outs("stale1", 0, FLUSH_CAUSE_NONE, 1, 32'h1c001000, 1, 1);
    @(negedge clk);
    check("ertn.drop_cnt", 32'(dut.u_tracker.drop_cnt));
    observe_outs("stale1"); tick();
    push("stale2.if_drop_data", 32'd1);
    @(negedge clk); check("stale2.if_drop_data", 32'(if_drop_data)); tick();
    clear_in();
    if_redirect_ack = 1'b1;
    push("stale_ack.outst_cnt", 32'd0);
    @(negedge clk); check("stale_ack.outst_cnt", 32'(dut.u_tracker.outst_cnt)); tick();
    clear_in();
    inst_sram_req = 1'b1; inst_sram_addr_ok = 1'b1;
    push("live_req.fetch_block", 32'd0);
    @(negedge clk); check("live_req.fetch_block", 32'(fetch_block)); tick();
    clear_in();
    inst_sram_data_ok = 1'b1;
    push("live_data.if_drop_data", 32'd0);
    @(negedge clk); check("live_data.if_drop_data", 32'(if_drop_data)); tick();
    clear_in();

    // Pending request at refetch flush
    inst_sram_req = 1'b1; wb_refetch_flush = 1'b1; wb_flush_entry = 32'h1c002000;
    expect_outs("refetch", 1, FLUSH_CAUSE_REFETCH, 0, 32'h1c001000, 0, 0);
    @(negedge clk); observe_outs("refetch"); tick();
    wb_refetch_flush = 1'b0; wb_flush_entry = 32'h0;
    push("pend.req_pend_drop", 32'd1);
    @(negedge clk); check("pend.req_pend_drop", 32'(dut.u_tracker.req_pend_drop)); tick();
    inst_sram_addr_ok = 1'b1;
    push("pend_acc.drop_cnt", 32'd0);
    @(negedge clk); check("pend_acc.drop_cnt", 32'(dut.u_tracker.drop_cnt)); tick();
    clear_in();
    inst_sram_data_ok = 1'b1;
    push("pend_data.drop_cnt", 32'd1);
    expect_outs("pend_data", 0, FLUSH_CAUSE_NONE, 1, 32'h1c002000, 1, 1);
    @(negedge clk);
    check("pend_data.drop_cnt", 32'(dut.u_tracker.drop_cnt));
    observe_outs("pend_data"); tick();
    clear_in();
    if_redirect_ack = 1'b1;
    tick();
    clear_in();
    inst_sram_req = 1'b1; inst_sram_addr_ok = 1'b1;
    tick();
    clear_in();
    inst_sram_data_ok = 1'b1;
    expect_outs("pend_live", 0, FLUSH_CAUSE_NONE, 0, 32'h1c002000, 0, 0);
    @(negedge clk); observe_outs("pend_live"); tick();
    clear_in();

    // Simultaneous sources: exception wins over refetch
    wb_ex = 1'b1; wb_refetch_flush = 1'b1; wb_flush_entry = 32'h1c003000;
    expect_outs("simul", 1, FLUSH_CAUSE_EX, 0, 32'h1c002000, 0, 0);
    @(negedge clk); observe_outs("simul"); tick();
    clear_in();

    // Back-to-back flush with ack in the same cycle
    wb_ex = 1'b1; if_redirect_ack = 1'b1; wb_flush_entry = 32'h1c000100;
    expect_outs("b2b", 1, FLUSH_CAUSE_EX, 1, 32'h1c003000, 0, 1);
    @(negedge clk); observe_outs("b2b"); tick();
    clear_in();
    push("b2b_hold.state", 32'(REDIR));
    expect_outs("b2b_hold", 0, FLUSH_CAUSE_NONE, 1, 32'h1c000100, 0, 1);
    @(negedge clk);
    check("b2b_hold.state", 32'(dut.state));
    observe_outs("b2b_hold"); tick();
    if_redirect_ack = 1'b1;
    tick();
    clear_in();
    expect_outs("b2b_done", 0, FLUSH_CAUSE_NONE, 0, 32'h1c000100, 0, 0);
    @(negedge clk); observe_outs("b2b_done"); tick();

    // Flush and data_ok together with one fetch outstanding
    inst_sram_req = 1'b1; inst_sram_addr_ok = 1'b1;
    tick();
    clear_in();
    wb_ex = 1'b1; inst_sram_data_ok = 1'b1; wb_flush_entry = 32'h1c004000;
    expect_outs("same_cyc", 1, FLUSH_CAUSE_EX, 0, 32'h1c000100, 1, 0);
    @(negedge clk); observe_outs("same_cyc"); tick();
    clear_in();
    push("same_cyc.drop_cnt", 32'd0);
    push("same_cyc.outst_cnt", 32'd0);
    expect_outs("same_cyc_after", 0, FLUSH_CAUSE_NONE, 1, 32'h1c004000, 0, 1);
    @(negedge clk);
    check("same_cyc.drop_cnt", 32'(dut.u_tracker.drop_cnt));
    check("same_cyc.outst_cnt", 32'(dut.u_tracker.outst_cnt));
    observe_outs("same_cyc_after"); tick();

    // Asynchronous reset mid-REDIR, between clock edges
    #3;
    resetn = 1'b0; wb_ex = 1'b1; inst_sram_data_ok = 1'b1; wb_flush_entry = 32'h1c005000;
    push("async_rst.state", 32'(IDLE));
    expect_outs("async_rst", 0, FLUSH_CAUSE_NONE, 0, 32'h0, 0, 0);
    #1;
    check("async_rst.state", 32'(dut.state));
    observe_outs("async_rst");
    @(negedge clk);
    clear_in();
    resetn = 1'b1;
    tick();

    // data_ok with nothing outstanding holds counters at zero
    inst_sram_data_ok = 1'b1;
    push("spur.if_drop_data", 32'd0);
    @(negedge clk); check("spur.if_drop_data", 32'(if_drop_data)); tick();
    clear_in();
    push("spur.outst_cnt", 32'd0);
    @(negedge clk); check("spur.outst_cnt", 32'(dut.u_tracker.outst_cnt)); tick();

    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/flush_ctrl.md
Name: flush_ctrl

Overview:
- Central pipeline-redirect sequencer between WB and IF.
- Merges WB flush sources (exception, ertn, refetch) into a single one-cycle flush to all stages.
- Holds the redirect target until IF accepts it.
- Tracks in-flight instruction-fetch transactions on the SRAM-like inst interface, so IF discards every stale response returned after a flush.

Parameters:
- MAX_OUTST, 2, maximum inst-fetch transactions in flight (address accepted, data not yet returned).
- CNT_W, 2, counter width; must hold 0..MAX_OUTST.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; one clock, reset is asynchronous and active-low.
- wb_ex  in  1  WB exception (already qualified with wb_valid).
- ertn_flush  in  1  WB ertn (already qualified).
- wb_refetch_flush  in  1  WB TLB/CSR refetch (already qualified).
- wb_flush_entry  in  32  target PC from WB.
- inst_sram_req  in  1  IF fetch request.
- inst_sram_addr_ok  in  1  address handshake.
- inst_sram_data_ok  in  1  data return.
- if_redirect_ack  in  1  IF consumed redirect_pc this cycle.
- flush_all  out  1  one-cycle flush to IF/ID/EX/MEM/WB.
- flush_cause  out  2  01 = exception, 10 = ertn, 11 = refetch, 00 = none.
- redirect_valid  out  1  redirect_pc is valid and pending.
- redirect_pc  out  32  PC IF must fetch next.
- if_drop_data  out  1  current data_ok is stale; IF must discard it.
- fetch_block  out  1  IF must not raise a new inst_sram_req.

Behaviour:
- Reset values (async, resetn low): state = IDLE; redirect_valid = 0; redirect_pc = 0; flush_cause = 00; outst_cnt = 0; drop_cnt = 0; req_pend_drop = 0.
- flush_ev = wb_ex | ertn_flush | wb_refetch_flush.
- flush_all = flush_ev, combinational, zero latency. It is forced to 0 while resetn is low.
- Cause priority: wb_ex > ertn_flush > wb_refetch_flush. flush_cause is combinational and valid only when flush_all = 1, else 00.
- FSM states:
  - IDLE: on flush_ev, latch redirect_pc <= wb_flush_entry and go to REDIR.
  - REDIR: redirect_valid = 1. On if_redirect_ack and no new flush_ev, go to IDLE (redirect_valid = 0 the next cycle).
  - REDIR + flush_ev in the same cycle (with or without ack): re-latch the new target, stay in REDIR. The newest flush always wins.
- fetch_block = (state == REDIR) | (outst_cnt == MAX_OUTST).
- outst_cnt (all in-flight transactions, stale or not):
  - +1 on req & addr_ok.
  - -1 on data_ok.
  - Both in the same cycle: unchanged.
  - Saturates; never wraps.
- drop_cnt:
  - On flush_ev: drop_cnt <= outst_cnt + (req & addr_ok) - data_ok. This is the count of transactions still outstanding after the current cycle.
  - Otherwise: decrements on data_ok while drop_cnt > 0.
  - A second flush recomputes drop_cnt from outst_cnt. No double counting.
- if_drop_data = inst_sram_data_ok & ((drop_cnt != 0) | flush_ev).
  - A data_ok coinciding with flush_ev is stale and is dropped.
  - It is not counted into drop_cnt.
- req_pend_drop:
  - Set on flush_ev when inst_sram_req & ~inst_sram_addr_ok. The protocol forbids retracting a raised req, so that request is already stale.
  - While set, the next req & addr_ok increments drop_cnt instead of being treated as live; the flag then clears.
  - A flush that arrives while the flag is set keeps it set.
- Only new requests made after the redirect ack (i.e. with drop_cnt reaching 0 or beyond) deliver live data. Responses are in order, so counting is sufficient.
- Boundaries:
  - data_ok with outst_cnt == 0 is a protocol error; counters hold at 0.
  - drop_cnt never exceeds MAX_OUTST + 1.
  - resetn asserted mid-REDIR clears everything asynchronously; no redirect survives reset.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - FLUSH_CAUSE_{NONE,EX,ERTN,REFETCH} codes.
  - FSM state encoding (IDLE = 1'b0, REDIR = 1'b1).
  - CSR number constants already used by WB (EENTRY 14'hc, TLBRENTRY 14'h88).
- One sub-module is natural: inflight_tracker, containing outst_cnt, drop_cnt, req_pend_drop and if_drop_data.
- The FSM and target register stay in flush_ctrl.

Test Plan:
- Idle flush: wb_ex = 1 for 1 cycle, wb_flush_entry = 32'h1c008000, no fetch in flight.
  - Expect flush_all = 1 and flush_cause = 01 that cycle.
  - Expect redirect_valid = 1, redirect_pc = 32'h1c008000 from the next cycle until ack.
  - Ack: redirect_valid = 0 the cycle after; fetch_block drops.
- Stale drop: 2 transactions accepted (outst_cnt = 2), then ertn_flush.
  - Expect flush_cause = 10, drop_cnt = 2.
  - Next two data_ok pulses give if_drop_data = 1; the third (after a new req) gives 0.
- Pending req: req = 1, addr_ok = 0 when wb_refetch_flush arrives; addr_ok 2 cycles later, data_ok 1 cycle after that.
  - Expect if_drop_data = 1 on that data_ok.
  - The following post-redirect fetch is live.
- Simultaneous sources: wb_ex = 1 and wb_refetch_flush = 1 together.
  - Expect flush_cause = 01.
- Back-to-back: second flush in REDIR with target 32'h1c000100, ack in the same cycle.
  - Expect state to stay REDIR, redirect_pc = 32'h1c000100, and one further ack required.
- Same-cycle corner: flush and data_ok together with outst_cnt = 1.
  - Expect if_drop_data = 1 that cycle and drop_cnt = 0 afterwards.
- Async reset: assert resetn = 0 mid-REDIR between clock edges.
  - Expect all outputs at reset values immediately, without waiting for an edge.
